// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small {pc, instr} buffer between imem responses and decode, synchronous clear
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [2:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    fetch_entry_t   mem [2**AW];
    logic [AW-1:0]  rd_q, wr_q;
    logic [2:0]     count_q;
    logic           do_pop;
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    assign empty  = count_q == 3'd0;
    assign full   = count_q == 3'(DEPTH);
    assign count  = count_q;
    assign do_pop = pop && !empty;
    assign head   = mem[rd_q];
    // storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk)
        if (push && !clear) mem[wr_q] <= push_data;
    // pointers and occupancy; clear wins over a same-cycle push or pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (clear) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= bump(wr_q);
            if (do_pop) rd_q <= bump(rd_q);
            count_q <= count_q + {2'b0, push} - {2'b0, do_pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, in-order imem requests and decode buffer; FETCH_MISALIGN_TRAP_EN adds a halt on misaligned redirects
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        ex_jalr_valid,
    input  logic [31:0] ex_jalr_address,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        flush_out
`ifdef FETCH_MISALIGN_TRAP_EN
    ,output logic       if_misaligned
`endif
);
    fetch_state_t state_q;
    logic [31:0]  pc_q, resp_pc_q, raw_target, target;
    logic [2:0]   outstanding_q, outstanding_d, discard_q, occupancy;
    logic         redirect, misaligned, req_fire, drop, push, pop, fifo_full, fifo_empty;
    fetch_entry_t head, push_entry;

    assign redirect   = ex_jalr_valid | ex_branch_taken;
    assign raw_target = ex_jalr_valid ? (ex_jalr_address & ~32'h1) : ex_branch_target;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = raw_target;
    assign misaligned = raw_target[1:0] != 2'b00;
`else
    assign target     = raw_target & ~32'h3;
    assign misaligned = 1'b0;
`endif
    // a pop this cycle frees its slot, which keeps 1-cycle memory at one instruction per cycle
    assign pop            = if_ready && !fifo_empty && !redirect;
    assign imem_req_valid = (state_q == RUN) && !redirect && !fifo_full &&
                            ({1'b0, outstanding_q} + {1'b0, occupancy} - {3'b0, pop} < 4'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign drop           = discard_q != 3'd0;
    assign push           = imem_resp_valid && !drop;
    assign outstanding_d  = outstanding_q + {2'b0, req_fire} - {2'b0, imem_resp_valid};
    assign push_entry     = '{pc: resp_pc_q, instr: imem_resp_data};
    assign flush_out      = redirect;
    assign if_valid       = !fifo_empty;
    assign if_pc          = fifo_empty ? 32'h0 : head.pc;
    assign if_instruction = fifo_empty ? INSTR_NOP : head.instr;

    // FSM, fetch PC, response PC and in-flight accounting; a redirect overrides sequential fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect) begin
                state_q   <= misaligned ? HALT : RUN;
                pc_q      <= target;
                resp_pc_q <= target;
                discard_q <= outstanding_d;
            end else begin
                if (state_q == IDLE) state_q <= RUN;
                if (req_fire) pc_q <= pc_q + 32'd4;
                if (push) resp_pc_q <= resp_pc_q + 32'd4;
                if (imem_resp_valid && drop) discard_q <= discard_q - 3'd1;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // misalignment flag, re-evaluated on every redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) if_misaligned <= 1'b0;
        else if (redirect) if_misaligned <= misaligned;
    end
`endif

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );
endmodule
